// File: rtl/tec_encoder_if.sv
// Handshake bundle for tec_encoder.
//   in_valid/in_data/in_ready    : word input handshake
//   out_valid/out_ready          : codeword output handshake
//   out_data/out_chk_a/out_chk_b/out_par : codeword fields, held while out_valid
// The slave modport is the encoder side; master is the producer/consumer side.
interface tec_encoder_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [6:0]  out_chk_a;
  logic [7:0]  out_chk_b;
  logic        out_par;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chk_a, out_chk_b, out_par
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chk_a, out_chk_b, out_par
  );
endinterface

// File: rtl/tec_encoder.sv
// Byte-serial encoder for the 32-bit triple-error-detecting code.
// Produces check field A (7 bits), check field B (8 bits) and overall parity,
// one data byte per cycle, four cycles per word.
//   clk        : rising-edge clock
//   rst        : synchronous, active-high reset
//   bus        : handshake bundle (slave side), see tec_encoder_if
//   word_count : number of completed output handshakes, wraps at 16 bits
module tec_encoder (
  input  logic          clk,
  input  logic          rst,
  tec_encoder_if.slave  bus,
  output logic [15:0]   word_count
);

  typedef enum logic [1:0] {StIdle, StEnc, StDone} state_e;

  // Column A(i): i-th 7-bit value of weight 3, ascending.
  function automatic logic [6:0] col_a(input logic [4:0] i);
    logic [6:0] v;
    case (i)
      5'd0:  v = 7'h07;  5'd1:  v = 7'h0B;  5'd2:  v = 7'h0D;  5'd3:  v = 7'h0E;
      5'd4:  v = 7'h13;  5'd5:  v = 7'h15;  5'd6:  v = 7'h16;  5'd7:  v = 7'h19;
      5'd8:  v = 7'h1A;  5'd9:  v = 7'h1C;  5'd10: v = 7'h23;  5'd11: v = 7'h25;
      5'd12: v = 7'h26;  5'd13: v = 7'h29;  5'd14: v = 7'h2A;  5'd15: v = 7'h2C;
      5'd16: v = 7'h31;  5'd17: v = 7'h32;  5'd18: v = 7'h34;  5'd19: v = 7'h38;
      5'd20: v = 7'h43;  5'd21: v = 7'h45;  5'd22: v = 7'h46;  5'd23: v = 7'h49;
      5'd24: v = 7'h4A;  5'd25: v = 7'h4C;  5'd26: v = 7'h51;  5'd27: v = 7'h52;
      5'd28: v = 7'h54;  5'd29: v = 7'h58;  5'd30: v = 7'h61;  default: v = 7'h62;
    endcase
    return v;
  endfunction

  // Column B(i): i-th 8-bit value of weight 3, descending.
  function automatic logic [7:0] col_b(input logic [4:0] i);
    logic [7:0] v;
    case (i)
      5'd0:  v = 8'hE0;  5'd1:  v = 8'hD0;  5'd2:  v = 8'hC8;  5'd3:  v = 8'hC4;
      5'd4:  v = 8'hC2;  5'd5:  v = 8'hC1;  5'd6:  v = 8'hB0;  5'd7:  v = 8'hA8;
      5'd8:  v = 8'hA4;  5'd9:  v = 8'hA2;  5'd10: v = 8'hA1;  5'd11: v = 8'h98;
      5'd12: v = 8'h94;  5'd13: v = 8'h92;  5'd14: v = 8'h91;  5'd15: v = 8'h8C;
      5'd16: v = 8'h8A;  5'd17: v = 8'h89;  5'd18: v = 8'h86;  5'd19: v = 8'h85;
      5'd20: v = 8'h83;  5'd21: v = 8'h70;  5'd22: v = 8'h68;  5'd23: v = 8'h64;
      5'd24: v = 8'h62;  5'd25: v = 8'h61;  5'd26: v = 8'h58;  5'd27: v = 8'h54;
      5'd28: v = 8'h52;  5'd29: v = 8'h51;  5'd30: v = 8'h4C;  default: v = 8'h4A;
    endcase
    return v;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [6:0]  acc_a_q, acc_a_d;
  logic [7:0]  acc_b_q, acc_b_d;
  logic [31:0] out_data_q, out_data_d;
  logic [6:0]  chk_a_q, chk_a_d;
  logic [7:0]  chk_b_q, chk_b_d;
  logic        par_q, par_d;
  logic [15:0] word_count_q, word_count_d;

  // Contribution of the current byte to each check field.
  logic [6:0] byte_a;
  logic [7:0] byte_b;

  always_comb begin
    byte_a = '0;
    byte_b = '0;
    for (int j = 0; j < 8; j++) begin
      if (data_q[{byte_idx_q, 3'(j)}]) begin
        byte_a = byte_a ^ col_a({byte_idx_q, 3'(j)});
        byte_b = byte_b ^ col_b({byte_idx_q, 3'(j)});
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    byte_idx_d   = byte_idx_q;
    acc_a_d      = acc_a_q;
    acc_b_d      = acc_b_q;
    out_data_d   = out_data_q;
    chk_a_d      = chk_a_q;
    chk_b_d      = chk_b_q;
    par_d        = par_q;
    word_count_d = word_count_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          data_d     = bus.in_data;
          acc_a_d    = '0;
          acc_b_d    = '0;
          byte_idx_d = '0;
          state_d    = StEnc;
        end
      end
      StEnc: begin
        acc_a_d = acc_a_q ^ byte_a;
        acc_b_d = acc_b_q ^ byte_b;
        if (byte_idx_q == 2'd3) begin
          // Output fields update only here, so they stay stable through DONE and IDLE.
          out_data_d = data_q;
          chk_a_d    = acc_a_d;
          chk_b_d    = acc_b_d;
          par_d      = (^data_q) ^ (^acc_a_d) ^ (^acc_b_d);
          state_d    = StDone;
        end else begin
          byte_idx_d = byte_idx_q + 2'd1;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          word_count_d = word_count_q + 16'd1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      data_q       <= '0;
      byte_idx_q   <= '0;
      acc_a_q      <= '0;
      acc_b_q      <= '0;
      out_data_q   <= '0;
      chk_a_q      <= '0;
      chk_b_q      <= '0;
      par_q        <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      byte_idx_q   <= byte_idx_d;
      acc_a_q      <= acc_a_d;
      acc_b_q      <= acc_b_d;
      out_data_q   <= out_data_d;
      chk_a_q      <= chk_a_d;
      chk_b_q      <= chk_b_d;
      par_q        <= par_d;
      word_count_q <= word_count_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_data  = out_data_q;
  assign bus.out_chk_a = chk_a_q;
  assign bus.out_chk_b = chk_b_q;
  assign bus.out_par   = par_q;
  assign word_count    = word_count_q;

endmodule

// File: tb/tb_tec_encoder.sv
// Scoreboard bench for tec_encoder: the driver pushes the expected codeword on
// acceptance, an independent monitor pops and compares on each output handshake.
module tb_tec_encoder;

  typedef struct {
    logic [31:0] d;
    logic [6:0]  a;
    logic [7:0]  b;
    logic        p;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] word_count;

  tec_encoder_if bus ();

  tec_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  exp_t        sb_q[$];
  logic [15:0] exp_count = '0;
  logic [6:0]  ref_a[32];
  logic [7:0]  ref_b[32];
  bit          rand_ready = 1'b0;
  logic        ready_fixed = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Columns derived from the code definition: weight-3 values in value order.
  task automatic build_columns();
    int n;
    n = 0;
    for (int v = 0; v < 128; v++) begin
      if ($countones(v) == 3 && n < 32) begin
        ref_a[n] = v[6:0];
        n++;
      end
    end
    n = 0;
    for (int v = 255; v >= 0; v--) begin
      if ($countones(v) == 3 && n < 32) begin
        ref_b[n] = v[7:0];
        n++;
      end
    end
  endtask

  function automatic exp_t model(input logic [31:0] d);
    exp_t e;
    e.d = d;
    e.a = '0;
    e.b = '0;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) begin
        e.a ^= ref_a[i];
        e.b ^= ref_b[i];
      end
    end
    e.p = ^{d, e.a, e.b};
    return e;
  endfunction

  // Single driver of out_ready, applied after the main process's #1 updates.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Monitor: handshake is decided at the next rising edge, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got word %0h, required no output", bus.out_data);
        end else begin
          exp_t e;
          int   bad;
          e = sb_q.pop_front();
          check("out_data", 64'(bus.out_data), 64'(e.d));
          check("chk_a", 64'(bus.out_chk_a), 64'(e.a));
          check("chk_b", 64'(bus.out_chk_b), 64'(e.b));
          check("par", 64'(bus.out_par), 64'(e.p));
          check("even_weight",
                64'($countones({bus.out_data, bus.out_chk_a, bus.out_chk_b, bus.out_par}) % 2),
                64'd0);
          bad = 0;
          for (int i = 0; i < 32; i++) begin
            exp_t f;
            logic [6:0] sa;
            logic [7:0] sbb;
            f   = model(bus.out_data ^ (32'd1 << i));
            sa  = bus.out_chk_a ^ f.a;
            sbb = bus.out_chk_b ^ f.b;
            if ($countones(sa) != 3 || $countones(sbb) != 3) bad++;
          end
          check("syndrome_weight3", 64'(bad), 64'd0);
          exp_count = exp_count + 16'd1;
          @(posedge clk);
          #1;
          check("word_count", 64'(word_count), 64'(exp_count));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input exp_t e, input bit push);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = e.d;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        $display("FAIL accept_timeout: got in_ready=0, required 1");
        $fatal(1, "accept timeout");
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (push) sb_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !bus.in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t        e;
    logic [48:0] snap;
    build_columns();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_fields", 64'({bus.out_data, bus.out_chk_a, bus.out_chk_b, bus.out_par}), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    rst = 1'b0;

    // Directed words with hand-derived codewords, plus latency.
    ready_fixed = 1'b1;
    send('{32'h0, 7'h00, 8'h00, 1'b0}, 1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check("latency_low", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    check("latency_high", 64'(bus.out_valid), 64'd1);
    send('{32'h1, 7'h07, 8'hE0, 1'b1}, 1);
    send('{32'h3, 7'h0C, 8'h30, 1'b0}, 1);
    send(model(32'hFFFF_FFFF), 1);
    send(model(32'h8000_0000), 1);
    drain();

    // Backpressure: fields hold, in_ready stays low, second word is not captured.
    ready_fixed = 1'b0;
    @(posedge clk);
    #1;
    send(model($urandom), 1);
    repeat (4) @(posedge clk);
    #1;
    check("bp_valid", 64'(bus.out_valid), 64'd1);
    snap = {bus.out_valid, bus.out_data, bus.out_chk_a, bus.out_chk_b, bus.out_par};
    bus.in_valid = 1'b1;
    bus.in_data  = $urandom;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_stable",
            64'({bus.out_valid, bus.out_data, bus.out_chk_a, bus.out_chk_b, bus.out_par}),
            64'(snap));
    end
    bus.in_valid = 1'b0;
    ready_fixed  = 1'b1;
    drain();
    send(model($urandom), 1);
    drain();

    // Reset while byte 2 is being processed: word must vanish.
    send(model($urandom), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_word_count", 64'(word_count), 64'd0);
    rst       = 1'b0;
    exp_count = '0;
    repeat (10) @(posedge clk);
    #1;

    // Random words with random backpressure and input gaps.
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      send(model($urandom), 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rand_ready = 1'b0;
    drain();

    // Counter wrap from a preloaded value.
    force dut.word_count_q = 16'hFFFE;
    #1;
    release dut.word_count_q;
    exp_count = 16'hFFFE;
    @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) send(model($urandom), 1);
    drain();
    check("wrap_final_count", 64'(word_count), 64'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
